// File: rtl/commit_mem_store_buffer_pkg.sv
// Shared definitions for the commit-to-memory store buffer: access width codes
// and default store-entry field widths.
package commit_mem_store_buffer_pkg;

    localparam int LSWIDTH_W = 2;
    typedef logic [LSWIDTH_W-1:0] lswidth_t;

    // Codes already understood by the AXI write controller.
    localparam lswidth_t LSWIDTH_BYTE = 2'd0;
    localparam lswidth_t LSWIDTH_HALF = 2'd1;
    localparam lswidth_t LSWIDTH_WORD = 2'd2;

    localparam int ST_DEPTH  = 8;
    localparam int ST_ADDR_W = 32;
    localparam int ST_DATA_W = 32;
    localparam int ST_STRB_W = ST_DATA_W / 8;

endpackage

// File: rtl/commit_mem_store_buffer_match.sv
// Word-address hazard comparator: flags any valid entry, or the incoming store,
// whose address falls in the same 32-bit word as the query.
module commit_mem_store_buffer_match #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0]             query_addr,
    input  logic [DEPTH-1:0][ADDR_W-1:0]  entry_addr,
    input  logic [DEPTH-1:0]              entry_valid,
    input  logic [ADDR_W-1:0]             new_addr,
    input  logic                          new_valid,
    output logic                          hit
);

    // Byte-offset bits are masked out so only the word address participates.
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    // NOTE: every output of a combinational block gets a default before any
    // conditional update, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        hit = new_valid && (((query_addr ^ new_addr) & WORD_MASK) == '0);
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (((query_addr ^ entry_addr[i]) & WORD_MASK) == '0)) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/commit_mem_store_buffer.sv
// In-order FIFO of retired stores feeding the AXI write controller, with a
// word-granular read-after-write query port for the load path.
module commit_mem_store_buffer
    import commit_mem_store_buffer_pkg::*;
#(
    parameter int DEPTH  = ST_DEPTH,
    parameter int ADDR_W = ST_ADDR_W,
    parameter int DATA_W = ST_DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_st_valid,
    output logic                o_st_ready,
    input  logic [ADDR_W-1:0]   i_st_addr,
    input  logic [DATA_W/8-1:0] i_st_strb,
    input  lswidth_t            i_st_lswidth,
    input  logic [DATA_W-1:0]   i_st_data,
    input  logic                i_st_uncached,
    output logic                o_wbmem_valid,
    output logic [ADDR_W-1:0]   o_wbmem_addr,
    output logic [DATA_W/8-1:0] o_wbmem_strb,
    output lswidth_t            o_wbmem_lswidth,
    output logic [DATA_W-1:0]   o_wbmem_data,
    output logic                o_wbmem_uncached,
    input  logic                i_wbmem_en,
    input  logic [ADDR_W-1:0]   i_query_addr,
    output logic                o_query_hit,
    output logic                o_empty
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int STRB_W = DATA_W / 8;

    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic             full, push, pop;

    logic [DEPTH-1:0][ADDR_W-1:0] addr_mem;
    logic [DEPTH-1:0][STRB_W-1:0] strb_mem;
    logic [DEPTH-1:0][DATA_W-1:0] data_mem;
    lswidth_t                     lsw_mem [DEPTH];
    logic [DEPTH-1:0]             unc_mem;

    // Occupancy comes only from count; pointers are equal both when empty and full.
    assign full          = (count == CNT_W'(DEPTH));
    assign o_empty       = (count == '0);
    assign o_st_ready    = ~full;
    assign o_wbmem_valid = ~o_empty;
    assign push          = i_st_valid && o_st_ready;
    assign pop           = o_wbmem_valid && i_wbmem_en;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: payload storage is deliberately not reset; an entry is only
    // observed once count covers it, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= i_st_addr;
            strb_mem[wr_ptr] <= i_st_strb;
            lsw_mem[wr_ptr]  <= i_st_lswidth;
            data_mem[wr_ptr] <= i_st_data;
            unc_mem[wr_ptr]  <= i_st_uncached;
        end
    end

    // Head is read straight from storage and holds until popped.
    assign o_wbmem_addr     = addr_mem[rd_ptr];
    assign o_wbmem_strb     = strb_mem[rd_ptr];
    assign o_wbmem_lswidth  = lsw_mem[rd_ptr];
    assign o_wbmem_data     = data_mem[rd_ptr];
    assign o_wbmem_uncached = unc_mem[rd_ptr];

    // A slot is live when its distance from the head is below the occupancy.
    logic [PTR_W-1:0] offset [DEPTH];
    logic [DEPTH-1:0] entry_valid;

    always_comb begin
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset[i]      = PTR_W'(i) - rd_ptr;
            entry_valid[i] = (CNT_W'(offset[i]) < count) && (strb_mem[i] != '0);
        end
    end

    commit_mem_store_buffer_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_match (
        .query_addr  (i_query_addr),
        .entry_addr  (addr_mem),
        .entry_valid (entry_valid),
        .new_addr    (i_st_addr),
        .new_valid   (push && (i_st_strb != '0)),
        .hit         (o_query_hit)
    );

endmodule

// File: tb/tb_commit_mem_store_buffer.sv
// Self-checking bench for the store buffer against a queue-based FIFO model.
module tb_commit_mem_store_buffer;
    import commit_mem_store_buffer_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [3:0]  st_strb;
    lswidth_t    st_lsw;
    logic [31:0] st_data;
    logic        st_unc;
    logic        wb_valid;
    logic [31:0] wb_addr;
    logic [3:0]  wb_strb;
    lswidth_t    wb_lsw;
    logic [31:0] wb_data;
    logic        wb_unc;
    logic        wb_en;
    logic [31:0] query_addr;
    logic        query_hit;
    logic        empty;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  strb;
        lswidth_t    lsw;
        logic [31:0] data;
        logic        unc;
    } st_t;

    st_t q[$];

    always #5 clk = ~clk;

    commit_mem_store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .i_st_valid       (st_valid),
        .o_st_ready       (st_ready),
        .i_st_addr        (st_addr),
        .i_st_strb        (st_strb),
        .i_st_lswidth     (st_lsw),
        .i_st_data        (st_data),
        .i_st_uncached    (st_unc),
        .o_wbmem_valid    (wb_valid),
        .o_wbmem_addr     (wb_addr),
        .o_wbmem_strb     (wb_strb),
        .o_wbmem_lswidth  (wb_lsw),
        .o_wbmem_data     (wb_data),
        .o_wbmem_uncached (wb_unc),
        .i_wbmem_en       (wb_en),
        .i_query_addr     (query_addr),
        .o_query_hit      (query_hit),
        .o_empty          (empty)
    );

    // Reference: any held store with nonzero strobes in the same word, or an accepted incoming one.
    function automatic bit exp_hit();
        bit h = 1'b0;
        foreach (q[i])
            if (q[i].strb != 0 && q[i].addr[31:2] == query_addr[31:2]) h = 1'b1;
        if (st_valid && q.size() < DEPTH && st_strb != 0 && st_addr[31:2] == query_addr[31:2])
            h = 1'b1;
        return h;
    endfunction

    // Advance one clock, applying FIFO semantics to the model; returns 2 ns after the edge.
    task automatic cycle();
        bit pu, po;
        pu = st_valid && (q.size() < DEPTH);
        po = wb_en && (q.size() > 0);
        @(posedge clk);
        if (reset) q.delete();
        else begin
            if (po) void'(q.pop_front());
            if (pu) q.push_back('{st_addr, st_strb, st_lsw, st_data, st_unc});
        end
        #2;
    endtask

    task automatic set_store(input logic [31:0] a, input logic [3:0] s, input lswidth_t w,
                             input logic [31:0] d, input logic u);
        st_valid = 1'b1; st_addr = a; st_strb = s; st_lsw = w; st_data = d; st_unc = u;
    endtask

    task automatic drain(input string tag);
        st_valid = 1'b0;
        wb_en    = 1'b1;
        for (int k = 0; k < DEPTH + 2 && q.size() > 0; k++) begin
            #1;
            n_checks++;
            if (wb_addr !== q[0].addr) begin
                n_fail++;
                $display("FAIL %s_order: head addr got %h expected %h", tag, wb_addr, q[0].addr);
            end
            cycle();
        end
        wb_en = 1'b0;
        #1;
        n_checks++;
        if (empty !== 1'b1 || q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drained: o_empty got %b expected 1 (model size %0d)", tag, empty, q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; st_valid = 1'b0; wb_en = 1'b0;
        st_addr = '0; st_strb = '0; st_lsw = LSWIDTH_WORD; st_data = '0; st_unc = 1'b0;
        query_addr = 32'h1000_0004;
        cycle(); cycle();
        reset = 1'b0;
        #1;
        n_checks++;
        if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", wb_valid); end
        n_checks++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
        n_checks++;
        if (st_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", st_ready); end
        n_checks++;
        if (query_hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %b expected 0", query_hit); end
    endtask

    task automatic test_single();
        set_store(32'h1000_0004, 4'hF, LSWIDTH_WORD, 32'hDEAD_BEEF, 1'b0);
        #1;
        n_checks++;
        if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: valid got %b expected 0", wb_valid); end
        cycle();
        st_valid = 1'b0;
        #1;
        n_checks++;
        if (wb_valid !== 1'b1 || wb_addr !== 32'h1000_0004 || wb_data !== 32'hDEAD_BEEF || wb_strb !== 4'hF)
        begin
            n_fail++;
            $display("FAIL single_head: got v=%b a=%h d=%h s=%h expected v=1 a=10000004 d=deadbeef s=f",
                     wb_valid, wb_addr, wb_data, wb_strb);
        end
        wb_en = 1'b1;
        cycle();
        wb_en = 1'b0;
        #1;
        n_checks++;
        if (wb_valid !== 1'b0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL single_pop: got v=%b empty=%b expected v=0 empty=1", wb_valid, empty);
        end
    endtask

    task automatic test_fill();
        wb_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_store(32'h3000_0000 + 32'(i * 4), 4'hF, LSWIDTH_WORD, $urandom, 1'(i & 1));
            cycle();
        end
        st_valid = 1'b0;
        #1;
        n_checks++;
        if (st_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready: got %b expected 0", st_ready); end
        set_store(32'h3000_0100, 4'hF, LSWIDTH_WORD, 32'h9999_9999, 1'b0);
        cycle();
        st_valid = 1'b0;
        #1;
        n_checks++;
        if (st_ready !== 1'b0 || wb_addr !== 32'h3000_0000) begin
            n_fail++;
            $display("FAIL fill_holdoff: ready=%b head=%h expected ready=0 head=30000000", st_ready, wb_addr);
        end
    endtask

    task automatic test_full_push_pop();
        set_store(32'h3000_0200, 4'hF, LSWIDTH_WORD, 32'h1234_5678, 1'b0);
        wb_en = 1'b1;
        #1;
        n_checks++;
        if (st_ready !== 1'b0) begin n_fail++; $display("FAIL fullpp_ready_same: got %b expected 0", st_ready); end
        cycle();
        st_valid = 1'b0; wb_en = 1'b0;
        #1;
        n_checks++;
        if (st_ready !== 1'b1 || wb_addr !== 32'h3000_0004) begin
            n_fail++;
            $display("FAIL fullpp_after: ready=%b head=%h expected ready=1 head=30000004", st_ready, wb_addr);
        end
        for (int i = 0; i < 20; i++) begin
            set_store(32'h3100_0000 + 32'(i * 4), 4'hF, LSWIDTH_HALF, $urandom, 1'b0);
            wb_en = 1'b1;
            #1;
            n_checks++;
            if (st_ready !== 1'b1 || wb_valid !== 1'b1 || wb_addr !== q[0].addr) begin
                n_fail++;
                $display("FAIL steady_pp[%0d]: ready=%b head=%h expected ready=1 head=%h",
                         i, st_ready, wb_addr, q[0].addr);
            end
            cycle();
        end
        drain("fullpp");
    endtask

    task automatic test_query();
        set_store(32'h2000_000B, 4'b1000, LSWIDTH_BYTE, 32'hAB00_0000, 1'b0);
        cycle();
        st_valid = 1'b0;
        query_addr = 32'h2000_0008;
        #1;
        n_checks++;
        if (query_hit !== 1'b1) begin n_fail++; $display("FAIL query_same_word: got %b expected 1", query_hit); end
        query_addr = 32'h2000_000C;
        #1;
        n_checks++;
        if (query_hit !== 1'b0) begin n_fail++; $display("FAIL query_next_word: got %b expected 0", query_hit); end
        set_store(32'h2000_000C, 4'b0001, LSWIDTH_BYTE, 32'h0000_00CD, 1'b0);
        #1;
        n_checks++;
        if (query_hit !== 1'b1) begin n_fail++; $display("FAIL query_incoming: got %b expected 1", query_hit); end
        st_strb = 4'b0000;
        #1;
        n_checks++;
        if (query_hit !== 1'b0) begin n_fail++; $display("FAIL query_zero_strb: got %b expected 0", query_hit); end
        st_valid = 1'b0;
        wb_en = 1'b1;
        query_addr = 32'h2000_0008;
        #1;
        n_checks++;
        if (query_hit !== 1'b1) begin n_fail++; $display("FAIL query_popping_head: got %b expected 1", query_hit); end
        cycle();
        wb_en = 1'b0;
        #1;
        n_checks++;
        if (query_hit !== 1'b0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL query_after_pop: hit=%b empty=%b expected hit=0 empty=1", query_hit, empty);
        end
    endtask

    task automatic test_hold();
        set_store(32'h5000_0010, 4'h3, LSWIDTH_HALF, 32'h0000_BEEF, 1'b1);
        cycle();
        for (int i = 0; i < 5; i++) begin
            set_store(32'h5100_0000 + 32'($urandom_range(0, 255) * 4), 4'hF, LSWIDTH_WORD, $urandom, 1'b0);
            wb_en = 1'b0;
            #1;
            n_checks++;
            if (wb_valid !== 1'b1 || wb_addr !== 32'h5000_0010 || wb_data !== 32'h0000_BEEF ||
                wb_strb !== 4'h3 || wb_lsw !== LSWIDTH_HALF || wb_unc !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_head[%0d]: got a=%h d=%h s=%h w=%0d u=%b expected a=50000010 d=0000beef s=3 w=1 u=1",
                         i, wb_addr, wb_data, wb_strb, wb_lsw, wb_unc);
            end
            cycle();
        end
        drain("hold");
        wb_en = 1'b1;
        cycle();
        wb_en = 1'b0;
        #1;
        n_checks++;
        if (wb_valid !== 1'b0 || empty !== 1'b1 || st_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_pop: v=%b empty=%b ready=%b expected 0 1 1", wb_valid, empty, st_ready);
        end
        set_store(32'h5200_0020, 4'hF, LSWIDTH_WORD, 32'hCAFE_F00D, 1'b0);
        cycle();
        st_valid = 1'b0;
        #1;
        n_checks++;
        if (wb_addr !== 32'h5200_0020 || wb_data !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL empty_pop_ptr: got a=%h d=%h expected a=52000020 d=cafef00d", wb_addr, wb_data);
        end
        drain("hold2");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            set_store(32'h4000_0010 + 32'(i * 4), 4'hF, LSWIDTH_WORD, $urandom, 1'b0);
            cycle();
        end
        st_valid = 1'b0;
        query_addr = 32'h4000_0014;
        #1;
        n_checks++;
        if (query_hit !== 1'b1) begin n_fail++; $display("FAIL rstmid_prehit: got %b expected 1", query_hit); end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        n_checks++;
        if (wb_valid !== 1'b0 || empty !== 1'b1 || query_hit !== 1'b0 || st_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_state: v=%b empty=%b hit=%b ready=%b expected 0 1 0 1",
                     wb_valid, empty, query_hit, st_ready);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            st_valid   = ($urandom_range(0, 99) < 60);
            st_addr    = 32'h6000_0000 + 32'($urandom_range(0, 31));
            st_strb    = 4'($urandom_range(0, 15));
            st_lsw     = lswidth_t'($urandom_range(0, 2));
            st_data    = $urandom;
            st_unc     = 1'($urandom_range(0, 1));
            wb_en      = ($urandom_range(0, 99) < 45);
            query_addr = 32'h6000_0000 + 32'($urandom_range(0, 31));
            #1;
            n_checks++;
            if (wb_valid !== (q.size() > 0) || empty !== (q.size() == 0) || st_ready !== (q.size() < DEPTH)) begin
                n_fail++;
                $display("FAIL rand_flags[%0d]: v=%b empty=%b ready=%b model size %0d", i, wb_valid, empty, st_ready, q.size());
            end
            n_checks++;
            if (query_hit !== exp_hit()) begin
                n_fail++;
                $display("FAIL rand_hit[%0d]: got %b expected %b (query %h)", i, query_hit, exp_hit(), query_addr);
            end
            if (q.size() > 0) begin
                n_checks++;
                if (wb_addr !== q[0].addr || wb_data !== q[0].data || wb_strb !== q[0].strb ||
                    wb_lsw !== q[0].lsw || wb_unc !== q[0].unc) begin
                    n_fail++;
                    $display("FAIL rand_head[%0d]: got a=%h d=%h s=%h w=%0d u=%b expected a=%h d=%h s=%h w=%0d u=%b",
                             i, wb_addr, wb_data, wb_strb, wb_lsw, wb_unc,
                             q[0].addr, q[0].data, q[0].strb, q[0].lsw, q[0].unc);
                end
            end
            cycle();
        end
        wb_en = 1'b0;
        drain("rand");
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_full_push_pop();
        test_query();
        test_hold();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
